control_unit: RTL and testbench

// - Hardwired Moore control sequencer that sits upstream of the datapath.
// - Decodes the IR contents and drives every datapath control strobe,
//   one T-state per clock.
// - Sequences fetch (T0-T2) and execute (T3-T7) for ld, ldi, st, add, sub,
//   and, or, addi, nop and halt.

---
 rtl/control_unit.sv | 264 ++++++++++++++++++++++++++
 tb/tb_control_unit.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// Hardwired Moore control sequencer: fetch in T0-T2, opcode-specific execute in T3-T7.
// Optional macro CU_STEP_EN adds input step_i so the T-states advance only when stepped.
module control_unit #(
    parameter int OPW  = 5,
    parameter int ALUW = 5
) (
    input  logic            clk_i,
    input  logic            clr_i,
`ifdef CU_STEP_EN
    input  logic            step_i,
`endif
    input  logic [31:0]     ir_i,
    output logic            run_o,
    output logic            illegal_o,
    output logic [ALUW-1:0] alu_op_o,
    output logic            read_o,
    output logic            write_o,
    output logic            BAout_o,
    output logic            Rin_o,
    output logic            Rout_o,
    output logic            Gra_o,
    output logic            Grb_o,
    output logic            Grc_o,
    output logic            CONN_in_o,
    output logic            MARin_o,
    output logic            MDRin_o,
    output logic            HIin_o,
    output logic            LOin_o,
    output logic            Yin_o,
    output logic            Zin_o,
    output logic            PCin_o,
    output logic            IRin_o,
    output logic            incPC_o,
    output logic            InPortIn_o,
    output logic            OutPortIn_o,
    output logic            HIout_o,
    output logic            LOout_o,
    output logic            ZHighOut_o,
    output logic            ZLowOut_o,
    output logic            MDRout_o,
    output logic            PCout_o,
    output logic            InPortOut_o,
    output logic            Cout_o
);

    localparam logic [OPW-1:0] OP_LD   = OPW'(5'b00000);
    localparam logic [OPW-1:0] OP_LDI  = OPW'(5'b00001);
    localparam logic [OPW-1:0] OP_ST   = OPW'(5'b00010);
    localparam logic [OPW-1:0] OP_ADD  = OPW'(5'b00011);
    localparam logic [OPW-1:0] OP_SUB  = OPW'(5'b00100);
    localparam logic [OPW-1:0] OP_AND  = OPW'(5'b00101);
    localparam logic [OPW-1:0] OP_OR   = OPW'(5'b00110);
    localparam logic [OPW-1:0] OP_ADDI = OPW'(5'b01100);
    localparam logic [OPW-1:0] OP_NOP  = OPW'(5'b11010);
    localparam logic [OPW-1:0] OP_HALT = OPW'(5'b11011);

    localparam logic [ALUW-1:0] ALU_NOP = ALUW'(5'b00000);
    localparam logic [ALUW-1:0] ALU_ADD = ALUW'(5'b00001);
    localparam logic [ALUW-1:0] ALU_SUB = ALUW'(5'b00010);
    localparam logic [ALUW-1:0] ALU_AND = ALUW'(5'b01010);
    localparam logic [ALUW-1:0] ALU_OR  = ALUW'(5'b01011);

    typedef enum logic [3:0] {
        S_RESET,
        S_T0,
        S_T1,
        S_T2,
        S_T3,
        S_T4,
        S_T5,
        S_T6,
        S_T7,
        S_HALT
    } state_t;

    state_t state_q;
    state_t state_d;
    logic   advance;

    logic [OPW-1:0]  opcode;
    logic            isLd;
    logic            isLdi;
    logic            isSt;
    logic            isRtype;
    logic            isAddi;
    logic            isNop;
    logic            isHalt;
    logic            isLegal;
    logic            isAddrCalc;
    logic [ALUW-1:0] rtypeAlu;
    logic            unusedIr;

    assign opcode   = ir_i[31 -: OPW];
    assign unusedIr = ^ir_i[31-OPW:0];

`ifdef CU_STEP_EN
    assign advance = step_i;
`else
    assign advance = 1'b1;
`endif

    always_comb begin
        isLd       = (opcode == OP_LD);
        isLdi      = (opcode == OP_LDI);
        isSt       = (opcode == OP_ST);
        isRtype    = (opcode == OP_ADD) || (opcode == OP_SUB) ||
                     (opcode == OP_AND) || (opcode == OP_OR);
        isAddi     = (opcode == OP_ADDI);
        isNop      = (opcode == OP_NOP);
        isHalt     = (opcode == OP_HALT);
        isLegal    = isLd || isLdi || isSt || isRtype || isAddi || isNop || isHalt;
        // ld, ldi and st all form their effective address as Rb + C through Y and Z
        isAddrCalc = isLd || isLdi || isSt;
        rtypeAlu   = ALU_NOP;
        case (opcode)
            OP_ADD:  rtypeAlu = ALU_ADD;
            OP_SUB:  rtypeAlu = ALU_SUB;
            OP_AND:  rtypeAlu = ALU_AND;
            OP_OR:   rtypeAlu = ALU_OR;
            default: rtypeAlu = ALU_NOP;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RESET: state_d = S_T0;
            S_T0:    state_d = S_T1;
            S_T1:    state_d = S_T2;
            S_T2:    state_d = S_T3;
            S_T3: begin
                if (isNop) begin
                    state_d = S_T0;
                end else if (isHalt || !isLegal) begin
                    state_d = S_HALT;
                end else begin
                    state_d = S_T4;
                end
            end
            S_T4:    state_d = S_T5;
            S_T5:    state_d = (isLd || isSt) ? S_T6 : S_T0;
            S_T6:    state_d = S_T7;
            S_T7:    state_d = S_T0;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_RESET;
        endcase
    end

    // clr wins over step so a held sequencer can always be recovered
    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            state_q <= S_RESET;
        end else if (advance) begin
            state_q <= state_d;
        end
    end

    always_comb begin
        read_o      = 1'b0;
        write_o     = 1'b0;
        BAout_o     = 1'b0;
        Rin_o       = 1'b0;
        Rout_o      = 1'b0;
        Gra_o       = 1'b0;
        Grb_o       = 1'b0;
        Grc_o       = 1'b0;
        CONN_in_o   = 1'b0;
        MARin_o     = 1'b0;
        MDRin_o     = 1'b0;
        HIin_o      = 1'b0;
        LOin_o      = 1'b0;
        Yin_o       = 1'b0;
        Zin_o       = 1'b0;
        PCin_o      = 1'b0;
        IRin_o      = 1'b0;
        incPC_o     = 1'b0;
        InPortIn_o  = 1'b0;
        OutPortIn_o = 1'b0;
        HIout_o     = 1'b0;
        LOout_o     = 1'b0;
        ZHighOut_o  = 1'b0;
        ZLowOut_o   = 1'b0;
        MDRout_o    = 1'b0;
        PCout_o     = 1'b0;
        InPortOut_o = 1'b0;
        Cout_o      = 1'b0;
        alu_op_o    = ALU_NOP;
        run_o       = (state_q != S_HALT);
        illegal_o   = (state_q == S_HALT) && !isLegal;
        case (state_q)
            S_T0: begin
                PCout_o = 1'b1;
                MARin_o = 1'b1;
                incPC_o = 1'b1;
                Zin_o   = 1'b1;
            end
            S_T1: begin
                ZLowOut_o = 1'b1;
                PCin_o    = 1'b1;
                read_o    = 1'b1;
                MDRin_o   = 1'b1;
            end
            S_T2: begin
                MDRout_o = 1'b1;
                IRin_o   = 1'b1;
            end
            S_T3: begin
                if (isAddrCalc) begin
                    Grb_o   = 1'b1;
                    BAout_o = 1'b1;
                    Yin_o   = 1'b1;
                end else if (isRtype || isAddi) begin
                    Grb_o  = 1'b1;
                    Rout_o = 1'b1;
                    Yin_o  = 1'b1;
                end
            end
            S_T4: begin
                if (isAddrCalc || isAddi) begin
                    Cout_o   = 1'b1;
                    Zin_o    = 1'b1;
                    alu_op_o = ALU_ADD;
                end else if (isRtype) begin
                    Grc_o    = 1'b1;
                    Rout_o   = 1'b1;
                    Zin_o    = 1'b1;
                    alu_op_o = rtypeAlu;
                end
            end
            S_T5: begin
                if (isLd || isSt) begin
                    ZLowOut_o = 1'b1;
                    MARin_o   = 1'b1;
                end else if (isLdi || isRtype || isAddi) begin
                    ZLowOut_o = 1'b1;
                    Gra_o     = 1'b1;
                    Rin_o     = 1'b1;
                end
            end
            S_T6: begin
                if (isSt) begin
                    Gra_o   = 1'b1;
                    Rout_o  = 1'b1;
                    MDRin_o = 1'b1;
                end else if (isLd) begin
                    read_o  = 1'b1;
                    MDRin_o = 1'b1;
                end
            end
            S_T7: begin
                if (isSt) begin
                    write_o = 1'b1;
                end else if (isLd) begin
                    MDRout_o = 1'b1;
                    Gra_o    = 1'b1;
                    Rin_o    = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: the driver queues the expected strobe vector for
// each edge it issues and an independent monitor pops and compares after every edge.
module tb_control_unit;

    localparam logic [27:0] M_READ    = 28'd1 << 0;
    localparam logic [27:0] M_WRITE   = 28'd1 << 1;
    localparam logic [27:0] M_BAOUT   = 28'd1 << 2;
    localparam logic [27:0] M_RIN     = 28'd1 << 3;
    localparam logic [27:0] M_ROUT    = 28'd1 << 4;
    localparam logic [27:0] M_GRA     = 28'd1 << 5;
    localparam logic [27:0] M_GRB     = 28'd1 << 6;
    localparam logic [27:0] M_GRC     = 28'd1 << 7;
    localparam logic [27:0] M_MARIN   = 28'd1 << 9;
    localparam logic [27:0] M_MDRIN   = 28'd1 << 10;
    localparam logic [27:0] M_YIN     = 28'd1 << 13;
    localparam logic [27:0] M_ZIN     = 28'd1 << 14;
    localparam logic [27:0] M_PCIN    = 28'd1 << 15;
    localparam logic [27:0] M_IRIN    = 28'd1 << 16;
    localparam logic [27:0] M_INCPC   = 28'd1 << 17;
    localparam logic [27:0] M_ZLOWOUT = 28'd1 << 23;
    localparam logic [27:0] M_MDROUT  = 28'd1 << 24;
    localparam logic [27:0] M_PCOUT   = 28'd1 << 25;
    localparam logic [27:0] M_COUT    = 28'd1 << 27;

    // expected vector layout: {run, illegal, alu_op[4:0], strobes[27:0]}
    localparam logic [34:0] EXP_RESET = {1'b1, 1'b0, 5'b00000, 28'd0};
    localparam logic [34:0] EXP_IDLE  = {1'b1, 1'b0, 5'b00000, 28'd0};
    localparam logic [34:0] EXP_HALT  = {1'b0, 1'b0, 5'b00000, 28'd0};
    localparam logic [34:0] EXP_ILL   = {1'b0, 1'b1, 5'b00000, 28'd0};
    localparam logic [34:0] EXP_T0    = {1'b1, 1'b0, 5'b00000, M_PCOUT | M_MARIN | M_INCPC | M_ZIN};
    localparam logic [34:0] EXP_T1    = {1'b1, 1'b0, 5'b00000, M_ZLOWOUT | M_PCIN | M_READ | M_MDRIN};
    localparam logic [34:0] EXP_T2    = {1'b1, 1'b0, 5'b00000, M_MDROUT | M_IRIN};
    localparam logic [34:0] EXP_MEM3  = {1'b1, 1'b0, 5'b00000, M_GRB | M_BAOUT | M_YIN};
    localparam logic [34:0] EXP_MEM4  = {1'b1, 1'b0, 5'b00001, M_COUT | M_ZIN};
    localparam logic [34:0] EXP_MEM5  = {1'b1, 1'b0, 5'b00000, M_ZLOWOUT | M_MARIN};
    localparam logic [34:0] EXP_ST6   = {1'b1, 1'b0, 5'b00000, M_GRA | M_ROUT | M_MDRIN};
    localparam logic [34:0] EXP_ST7   = {1'b1, 1'b0, 5'b00000, M_WRITE};
    localparam logic [34:0] EXP_LD6   = {1'b1, 1'b0, 5'b00000, M_READ | M_MDRIN};
    localparam logic [34:0] EXP_LD7   = {1'b1, 1'b0, 5'b00000, M_MDROUT | M_GRA | M_RIN};
    localparam logic [34:0] EXP_R3    = {1'b1, 1'b0, 5'b00000, M_GRB | M_ROUT | M_YIN};
    localparam logic [34:0] EXP_ADD4  = {1'b1, 1'b0, 5'b00001, M_GRC | M_ROUT | M_ZIN};
    localparam logic [34:0] EXP_OR4   = {1'b1, 1'b0, 5'b01011, M_GRC | M_ROUT | M_ZIN};
    localparam logic [34:0] EXP_WB5   = {1'b1, 1'b0, 5'b00000, M_ZLOWOUT | M_GRA | M_RIN};

    localparam logic [31:0] IR_ST   = 32'h12000090;
    localparam logic [31:0] IR_LD   = 32'h00800075;
    localparam logic [31:0] IR_ADD  = 32'h18A30000;
    localparam logic [31:0] IR_OR   = 32'h30000000;
    localparam logic [31:0] IR_ADDI = 32'h60000000;
    localparam logic [31:0] IR_LDI  = 32'h08000000;
    localparam logic [31:0] IR_NOP  = 32'hD0000000;
    localparam logic [31:0] IR_HALT = 32'hD8000000;
    localparam logic [31:0] IR_BAD  = 32'hF8000000;

    typedef struct {
        string       name;
        logic [34:0] exp;
    } sbEntry_t;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic [31:0] ir = 32'd0;
    logic        run, illegal;
    logic [4:0]  aluOp;
    logic read, write, BAout, Rin, Rout, Gra, Grb, Grc, CONN_in, MARin, MDRin, HIin, LOin;
    logic Yin, Zin, PCin, IRin, incPC, InPortIn, OutPortIn, HIout, LOout, ZHighOut;
    logic ZLowOut, MDRout, PCout, InPortOut, Cout;
    logic [34:0] obs;
`ifdef CU_STEP_EN
    logic step = 1'b1;
`endif

    sbEntry_t sb[$];
    int checkCount = 0;
    int passCount = 0;

    always #5 clk = ~clk;

    control_unit dut (
        .clk_i(clk), .clr_i(clr),
`ifdef CU_STEP_EN
        .step_i(step),
`endif
        .ir_i(ir), .run_o(run), .illegal_o(illegal), .alu_op_o(aluOp),
        .read_o(read), .write_o(write), .BAout_o(BAout), .Rin_o(Rin), .Rout_o(Rout),
        .Gra_o(Gra), .Grb_o(Grb), .Grc_o(Grc), .CONN_in_o(CONN_in), .MARin_o(MARin),
        .MDRin_o(MDRin), .HIin_o(HIin), .LOin_o(LOin), .Yin_o(Yin), .Zin_o(Zin),
        .PCin_o(PCin), .IRin_o(IRin), .incPC_o(incPC), .InPortIn_o(InPortIn),
        .OutPortIn_o(OutPortIn), .HIout_o(HIout), .LOout_o(LOout), .ZHighOut_o(ZHighOut),
        .ZLowOut_o(ZLowOut), .MDRout_o(MDRout), .PCout_o(PCout), .InPortOut_o(InPortOut),
        .Cout_o(Cout)
    );

    assign obs = {run, illegal, aluOp,
                  Cout, InPortOut, PCout, MDRout, ZLowOut, ZHighOut, LOout, HIout,
                  OutPortIn, InPortIn, incPC, IRin, PCin, Zin, Yin, LOin, HIin,
                  MDRin, MARin, CONN_in, Grc, Grb, Gra, Rout, Rin, BAout, write, read};

    task automatic applyStimulus(input logic c, input logic [31:0] irv,
                                 input string name, input logic [34:0] exp);
        @(negedge clk);
        clr = c;
        ir  = irv;
        @(posedge clk);
        sb.push_back('{name, exp});
    endtask

    task automatic checkOutput(input string name, input logic [34:0] exp);
        checkCount++;
        if (obs === exp) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %h expected %h", name, obs, exp);
        end
    endtask

    // the monitor samples 1 time unit after each edge, once the decode has settled
    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            sbEntry_t e;
            e = sb.pop_front();
            checkOutput(e.name, e.exp);
        end
    end

    task automatic fetch(input logic [31:0] irv, input string tag);
        applyStimulus(1'b0, irv, {tag, "_T1"}, EXP_T1);
        applyStimulus(1'b0, irv, {tag, "_T2"}, EXP_T2);
    endtask

    initial begin
        applyStimulus(1'b1, 32'd0, "reset1", EXP_RESET);
        applyStimulus(1'b1, 32'd0, "reset2", EXP_RESET);
        applyStimulus(1'b0, IR_ST, "first_T0", EXP_T0);

        fetch(IR_ST, "st");
        applyStimulus(1'b0, IR_ST, "st_T3", EXP_MEM3);
        applyStimulus(1'b0, IR_ST, "st_T4", EXP_MEM4);
        applyStimulus(1'b0, IR_ST, "st_T5", EXP_MEM5);
        applyStimulus(1'b0, IR_ST, "st_T6", EXP_ST6);
        applyStimulus(1'b0, IR_ST, "st_T7", EXP_ST7);
        applyStimulus(1'b0, IR_ST, "st_T0", EXP_T0);

        fetch(IR_LD, "ld");
        applyStimulus(1'b0, IR_LD, "ld_T3", EXP_MEM3);
        applyStimulus(1'b0, IR_LD, "ld_T4", EXP_MEM4);
        applyStimulus(1'b0, IR_LD, "ld_T5", EXP_MEM5);
        applyStimulus(1'b0, IR_LD, "ld_T6", EXP_LD6);
        applyStimulus(1'b0, IR_LD, "ld_T7", EXP_LD7);
        applyStimulus(1'b0, IR_LD, "ld_T0", EXP_T0);

        fetch(IR_ADD, "add");
        applyStimulus(1'b0, IR_ADD, "add_T3", EXP_R3);
        applyStimulus(1'b0, IR_ADD, "add_T4", EXP_ADD4);
        applyStimulus(1'b0, IR_ADD, "add_T5", EXP_WB5);
        applyStimulus(1'b0, IR_ADD, "add_T0", EXP_T0);

        fetch(IR_OR, "or");
        applyStimulus(1'b0, IR_OR, "or_T3", EXP_R3);
        applyStimulus(1'b0, IR_OR, "or_T4", EXP_OR4);
        applyStimulus(1'b0, IR_OR, "or_T5", EXP_WB5);
        applyStimulus(1'b0, IR_OR, "or_T0", EXP_T0);

        fetch(IR_ADDI, "addi");
        applyStimulus(1'b0, IR_ADDI, "addi_T3", EXP_R3);
        applyStimulus(1'b0, IR_ADDI, "addi_T4", EXP_MEM4);
        applyStimulus(1'b0, IR_ADDI, "addi_T5", EXP_WB5);
        applyStimulus(1'b0, IR_ADDI, "addi_T0", EXP_T0);

        fetch(IR_LDI, "ldi");
        applyStimulus(1'b0, IR_LDI, "ldi_T3", EXP_MEM3);
        applyStimulus(1'b0, IR_LDI, "ldi_T4", EXP_MEM4);
        applyStimulus(1'b0, IR_LDI, "ldi_T5", EXP_WB5);
        applyStimulus(1'b0, IR_LDI, "ldi_T0", EXP_T0);

        fetch(IR_NOP, "nop");
        applyStimulus(1'b0, IR_NOP, "nop_T3", EXP_IDLE);
        applyStimulus(1'b0, IR_NOP, "nop_T0", EXP_T0);

        fetch(IR_HALT, "halt");
        applyStimulus(1'b0, IR_HALT, "halt_T3", EXP_IDLE);
        applyStimulus(1'b0, IR_HALT, "halt_enter", EXP_HALT);
        applyStimulus(1'b0, IR_HALT, "halt_hold", EXP_HALT);
        applyStimulus(1'b1, IR_HALT, "halt_clr", EXP_RESET);
        applyStimulus(1'b0, IR_BAD, "bad_T0", EXP_T0);

        fetch(IR_BAD, "bad");
        applyStimulus(1'b0, IR_BAD, "bad_T3", EXP_IDLE);
        applyStimulus(1'b0, IR_BAD, "bad_enter", EXP_ILL);
        applyStimulus(1'b0, IR_BAD, "bad_hold", EXP_ILL);
        applyStimulus(1'b1, IR_BAD, "bad_clr", EXP_RESET);
        applyStimulus(1'b0, IR_ST, "abort_T0", EXP_T0);

        fetch(IR_ST, "abort");
        applyStimulus(1'b0, IR_ST, "abort_T3", EXP_MEM3);
        applyStimulus(1'b0, IR_ST, "abort_T4", EXP_MEM4);
        applyStimulus(1'b0, IR_ST, "abort_T5", EXP_MEM5);
        applyStimulus(1'b0, IR_ST, "abort_T6", EXP_ST6);
        applyStimulus(1'b1, IR_ST, "abort_clr", EXP_RESET);
        applyStimulus(1'b0, IR_ST, "abort_T0b", EXP_T0);
        applyStimulus(1'b0, IR_ST, "abort_T1b", EXP_T1);

        for (int i = 0; i < 10 && sb.size() > 0; i++) begin
            @(posedge clk);
        end
        #2;
        if (sb.size() != 0) begin
            checkCount++;
            $display("[TB] FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
